// File: rtl/ahb_lockstep_checker.sv
// ahb_lockstep_checker: N-replica delayed-lockstep comparator with a zero-wait AHB-Lite
// status/control slave. Replica 0 runs DELAY cycles ahead and is realigned by a delay line.
// NREP=2 compares two replicas; NREP=3 adds a bitwise majority vote on vote_out.
// Optional feature: define LOCKSTEP_INJECT_EN to add the inject_mask port, which is XORed
// onto replica 1 before the compare and the vote.
module ahb_lockstep_checker #(
  parameter int NREP       = 2,
  parameter int W          = 32,
  parameter int DELAY      = 0,
  parameter int ERR_THRESH = 1
) (
  input  logic                HCLK,
  input  logic                HRESETn,
  input  logic [NREP*W-1:0]   rep_vec,
  output logic [W-1:0]        vote_out,
  output logic                DLS_ERROR,
  output logic                fault,
  output logic [NREP-1:0]     err_rep,
  input  logic                HSEL,
  input  logic                HREADY,
  input  logic                HWRITE,
  input  logic [1:0]          HTRANS,
  input  logic [31:0]         HADDR,
  input  logic [31:0]         HWDATA,
  output logic [31:0]         HRDATA,
  output logic                HREADYOUT
`ifdef LOCKSTEP_INJECT_EN
  ,
  input  logic [W-1:0]        inject_mask
`endif
);

  typedef enum logic [1:0] {ST_OK = 2'd0, ST_SUSPECT = 2'd1, ST_FAULT = 2'd2} state_t;

  localparam logic [3:0] THRESH    = 4'(ERR_THRESH);
  localparam logic [2:0] WARM_INIT = 3'(DELAY);

  logic [W-1:0]    r0d;
  logic [W-1:0]    r1;
  logic [W-1:0]    rep [NREP];
  logic [NREP-1:0] err_raw;
  logic [NREP-1:0] err_now;
  logic            compare_en;
  logic            mm;
  logic [W-1:0]    mask_reg;
  logic [2:0]      warm_reg;
  state_t          state_reg, state_next;
  logic [3:0]      run_reg, run_next, run_inc;
  logic [15:0]     count_reg, count_next;
  logic            dls_error_reg;
  logic [NREP-1:0] err_rep_reg;
  logic            wr_pend_reg;
  logic [11:0]     wr_addr_reg;
  logic [31:0]     hrdata_reg, rd_mux;
  logic            addr_valid, clr, mask_wr;
  logic            unused_bits;

  // Realign replica 0 with the trailing replicas.
  generate
    if (DELAY == 0) begin : g_no_delay
      assign r0d = rep_vec[W-1:0];
    end else begin : g_delay
      localparam int DW = DELAY * W;
      logic [DW-1:0] dly_reg;
      // Shift line: newest sample enters at the bottom, oldest leaves at the top.
      always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) dly_reg <= '0;
        else          dly_reg <= DW'({dly_reg, rep_vec[W-1:0]});
      end
      assign r0d = dly_reg[DW-1 -: W];
    end
  endgenerate

`ifdef LOCKSTEP_INJECT_EN
  assign r1 = rep_vec[W +: W] ^ inject_mask;
`else
  assign r1 = rep_vec[W +: W];
`endif

  assign rep[0] = r0d;
  assign rep[1] = r1;
  generate
    for (genvar gi = 2; gi < NREP; gi++) begin : g_rep
      assign rep[gi] = rep_vec[gi*W +: W];
    end

    if (NREP == 3) begin : g_vote3
      logic [W-1:0] maj;
      assign maj      = (rep[0] & rep[1]) | (rep[0] & rep[2]) | (rep[1] & rep[2]);
      assign vote_out = maj;
      for (genvar gi = 0; gi < NREP; gi++) begin : g_err
        assign err_raw[gi] = |((rep[gi] ^ maj) & mask_reg);
      end
    end else begin : g_vote2
      assign vote_out = rep[0];
      assign err_raw  = {NREP{|((rep[0] ^ rep[1]) & mask_reg)}};
    end
  endgenerate

  // Nothing is compared until the delay line holds real replica-0 samples.
  assign compare_en = (warm_reg == 3'd0);
  assign err_now    = compare_en ? err_raw : '0;
  assign mm         = |err_now;

  // Bus decode: writes land in the data phase that follows a registered address phase.
  assign addr_valid = HSEL & HREADY & HTRANS[1];
  assign clr        = wr_pend_reg && (wr_addr_reg == 12'h000) && HWDATA[0];
  assign mask_wr    = wr_pend_reg && (wr_addr_reg == 12'h008);
  assign run_inc    = run_reg + 4'd1;

  // Read data multiplexer, sampled at the end of the address phase.
  always_comb begin
    rd_mux = '0;
    case (HADDR[11:0])
      12'h000: rd_mux = {24'd0, run_reg, state_reg, dls_error_reg, fault};
      12'h004: rd_mux = {16'd0, count_reg};
      12'h008: rd_mux = 32'(mask_reg);
      default: rd_mux = '0;
    endcase
  end

  // Fault filter: consecutive mismatches escalate; a clear always wins over a mismatch.
  always_comb begin
    state_next = state_reg;
    run_next   = run_reg;
    if (clr) begin
      state_next = ST_OK;
      run_next   = '0;
    end else begin
      case (state_reg)
        ST_OK: begin
          if (mm) begin
            if (ERR_THRESH == 1) begin
              state_next = ST_FAULT;
            end else begin
              state_next = ST_SUSPECT;
              run_next   = 4'd1;
            end
          end
        end
        ST_SUSPECT: begin
          if (mm) begin
            run_next = run_inc;
            if (run_inc == THRESH) state_next = ST_FAULT;
          end else begin
            state_next = ST_OK;
            run_next   = '0;
          end
        end
        ST_FAULT: begin
          state_next = ST_FAULT;
        end
        default: begin
          state_next = ST_OK;
          run_next   = '0;
        end
      endcase
    end
  end

  // Saturating mismatch counter, cleared together with the fault.
  always_comb begin
    count_next = count_reg;
    if (clr)                              count_next = '0;
    else if (mm && (count_reg != 16'hFFFF)) count_next = count_reg + 16'd1;
  end

  // Checker state, flags, warm-up countdown and compare mask.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      warm_reg      <= WARM_INIT;
      state_reg     <= ST_OK;
      run_reg       <= '0;
      count_reg     <= '0;
      dls_error_reg <= 1'b0;
      err_rep_reg   <= '0;
      mask_reg      <= '1;
    end else begin
      if (warm_reg != 3'd0) warm_reg <= warm_reg - 3'd1;
      state_reg     <= state_next;
      run_reg       <= run_next;
      count_reg     <= count_next;
      dls_error_reg <= mm;
      err_rep_reg   <= err_now;
      if (mask_wr) mask_reg <= HWDATA[W-1:0];
    end
  end

  // AHB address-phase capture and registered read data.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_pend_reg <= 1'b0;
      wr_addr_reg <= '0;
      hrdata_reg  <= '0;
    end else if (HREADY) begin
      wr_pend_reg <= addr_valid & HWRITE;
      wr_addr_reg <= HADDR[11:0];
      hrdata_reg  <= (addr_valid && !HWRITE) ? rd_mux : 32'd0;
    end
  end

  assign fault       = (state_reg == ST_FAULT);
  assign DLS_ERROR   = dls_error_reg;
  assign err_rep     = err_rep_reg;
  assign HRDATA      = hrdata_reg;
  assign HREADYOUT   = 1'b1;
  assign unused_bits = ^{HADDR[31:12], HWDATA, HTRANS[0]};

endmodule
